// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b datapath types, including the instruction fetch FSM states.
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef enum logic [1:0] {IDLE, READ, LOAD} lc3b_ifetch_state;
endpackage

// File: rtl/ifetch_unit_watchdog.sv
// ifetch_watchdog: counts READ cycles and flags when LIMIT of them have elapsed without completion.
module ifetch_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (clear) count <= '0;
        else if (en) count <= count + 1'b1;
    end
    // The LIMIT-th READ cycle is the one that sees count at LIMIT-1.
    assign expired = en && count == W'(LIMIT - 1);
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: LC-3b instruction fetch stage driving the IR load/in pair and returning PC+2.
// Optional READ watchdog enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_unit
    import lc3b_types::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch,
    input  logic [15:0] pc,
    input  logic        flush,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata,
    output logic        mem_read,
    output logic [15:0] mem_address,
    output logic        ir_load,
    output logic [15:0] ir_data,
    output logic [15:0] pc_plus2,
    output logic        busy,
    output logic        fault
);
    lc3b_ifetch_state state, state_nx;
    logic drop, accept, take, timeout;
    assign accept = (state == IDLE || state == LOAD) && fetch && !flush;
    assign take = state == READ && mem_resp && !drop && !flush;
    always_comb begin
        state_nx = accept ? READ :
                   state != READ ? IDLE :
                   mem_resp ? (take ? LOAD : IDLE) :
                   timeout ? IDLE : READ;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // Strobes are registered from the next state so they switch cleanly on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read    <= 1'b0;
            mem_address <= '0;
            ir_load     <= 1'b0;
            ir_data     <= '0;
            pc_plus2    <= '0;
            busy        <= 1'b0;
            drop        <= 1'b0;
        end else begin
            mem_read <= state_nx == READ;
            ir_load  <= state_nx == LOAD;
            busy     <= state_nx != IDLE;
            drop     <= accept ? 1'b0 : (state == READ && flush) ? 1'b1 : drop;
            if (accept) begin
                mem_address <= {pc[15:1], 1'b0};
                pc_plus2    <= pc + 16'd2;
            end
            if (take) ir_data <= mem_rdata;
        end
    end
`ifdef IFETCH_TIMEOUT_EN
    logic expired;
    ifetch_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .en      (state == READ),
        .expired (expired)
    );
    assign timeout = expired && !mem_resp;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault <= 1'b0;
        else fault <= accept ? 1'b0 : (timeout | fault);
    end
`else
    assign timeout = 1'b0;
    // Always 0 here; the comparison only keeps TIMEOUT_CYCLES referenced.
    assign fault = TIMEOUT_CYCLES < 0;
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: transaction-level model of the fetch stage checked every cycle, plus literal spot checks.
module tb_ifetch_unit;
    logic clk = 1'b0, rst_n = 1'b0, fetch = 1'b0, flush = 1'b0, mem_resp = 1'b0;
    logic [15:0] pc = '0, mem_rdata = '0;
    logic mem_read, ir_load, busy, fault;
    logic [15:0] mem_address, ir_data, pc_plus2;
    int checks = 0, failures = 0;
    bit chk_en = 1'b0;
    logic e_mr, e_ld, e_busy, e_fault;
    logic [15:0] e_addr, e_ir, e_pc2;
    logic [15:0] cur_addr = '0, cur_ir = '0, cur_pc2 = '0;
    logic cur_fault = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
    localparam int MAXW = 3;
`else
    localparam int MAXW = 6;
`endif

    ifetch_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .fetch(fetch), .pc(pc), .flush(flush),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_read(mem_read),
        .mem_address(mem_address), .ir_load(ir_load), .ir_data(ir_data),
        .pc_plus2(pc_plus2), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_read", 16'(mem_read), 16'(e_mr));
            chk("mem_address", mem_address, e_addr);
            chk("ir_load", 16'(ir_load), 16'(e_ld));
            chk("ir_data", ir_data, e_ir);
            chk("pc_plus2", pc_plus2, e_pc2);
            chk("busy", 16'(busy), 16'(e_busy));
            chk("fault", 16'(fault), 16'(e_fault));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_mr = 1'b0; e_ld = 1'b0; e_busy = 1'b0; e_fault = cur_fault;
        e_addr = cur_addr; e_pc2 = cur_pc2; e_ir = cur_ir;
    endtask

    task automatic set_read();
        e_mr = 1'b1; e_ld = 1'b0; e_busy = 1'b1; e_fault = 1'b0;
        e_addr = cur_addr; e_pc2 = cur_pc2; e_ir = cur_ir;
    endtask

    // A cycle with no acceptable request: either no fetch, or fetch masked by flush.
    task automatic idle_step();
        step();
        set_idle();
        fetch = 1'($urandom);
        flush = fetch;
        pc = 16'($urandom);
        mem_resp = 1'b0;
    endtask

    // Issue a fetch from the current (IDLE or LOAD) cycle: w wait cycles, flush in READ cycle fl (-1 none).
    task automatic run_txn(input logic [15:0] p, input int w, input int fl, input logic [15:0] d);
        fetch = 1'b1; pc = p; flush = 1'b0;
        cur_addr = p & 16'hFFFE;
        cur_pc2 = p + 16'd2;
        cur_fault = 1'b0;
        for (int i = 0; i <= w; i++) begin
            step();
            set_read();
            fetch = 1'($urandom);
            pc = 16'($urandom);
            flush = (i == fl);
            mem_resp = (i == w);
            mem_rdata = (i == w) ? d : 16'($urandom);
        end
        step();
        mem_resp = 1'b0; flush = 1'b0; fetch = 1'b0; pc = 16'($urandom);
        if (fl >= 0 && fl <= w) set_idle();
        else begin
            cur_ir = d;
            set_idle();
            e_ld = 1'b1;
            e_busy = 1'b1;
        end
    endtask

`ifdef IFETCH_TIMEOUT_EN
    task automatic run_timeout(input logic [15:0] p);
        fetch = 1'b1; pc = p; flush = 1'b0;
        cur_addr = p & 16'hFFFE;
        cur_pc2 = p + 16'd2;
        cur_fault = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            set_read();
            fetch = 1'b0;
            mem_resp = 1'b0;
        end
        step();
        cur_fault = 1'b1;
        set_idle();
        chk("lit_fault_set", 16'(fault), 16'd1);
        chk("lit_timeout_noload", 16'(ir_load), 16'd0);
    endtask
`endif

    initial begin
        step();
        step();
        rst_n = 1'b1;
        set_idle();
        chk_en = 1'b1;
        chk("lit_rst_mem_read", 16'(mem_read), 16'd0);
        chk("lit_rst_pc_plus2", pc_plus2, 16'd0);
        idle_step();
        run_txn(16'h3001, 0, -1, 16'h1261);
        chk("lit_addr_3000", mem_address, 16'h3000);
        chk("lit_ir_1261", ir_data, 16'h1261);
        chk("lit_pc2_3003", pc_plus2, 16'h3003);
        chk("lit_load_strobe", 16'(ir_load), 16'd1);
        step();
        set_idle();
        chk("lit_back_idle", 16'(busy), 16'd0);
        run_txn(16'hFFFE, 3, -1, 16'hBEEF);
        chk("lit_pc2_wrap", pc_plus2, 16'h0000);
        step();
        set_idle();
        run_txn(16'h0200, 3, 1, 16'hDEAD);
        chk("lit_flush_ir_kept", ir_data, 16'hBEEF);
        chk("lit_flush_not_busy", 16'(busy), 16'd0);
        for (int k = 0; k < 6; k++) run_txn(16'($urandom), 0, -1, 16'($urandom));
        idle_step();
`ifdef IFETCH_TIMEOUT_EN
        run_timeout(16'h4000);
        idle_step();
        run_txn(16'h0100, 0, -1, 16'h5555);
        chk("lit_fault_cleared", 16'(fault), 16'd0);
        step();
        set_idle();
`endif
        // Asynchronous reset in the middle of a READ.
        fetch = 1'b1; pc = 16'h1234; flush = 1'b0;
        cur_addr = 16'h1234; cur_pc2 = 16'h1236; cur_fault = 1'b0;
        step();
        set_read();
        fetch = 1'b0; mem_resp = 1'b0;
        step();
        set_read();
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("lit_arst_mem_read", 16'(mem_read), 16'd0);
        chk("lit_arst_busy", 16'(busy), 16'd0);
        chk("lit_arst_addr", mem_address, 16'd0);
        chk("lit_arst_ir_data", ir_data, 16'd0);
        chk("lit_arst_pc2", pc_plus2, 16'd0);
        chk("lit_arst_ir_load", 16'(ir_load), 16'd0);
        chk("lit_arst_fault", 16'(fault), 16'd0);
        cur_addr = '0; cur_pc2 = '0; cur_ir = '0; cur_fault = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        set_idle();
        chk_en = 1'b1;
        run_txn(16'h2222, 1, -1, 16'hA5A5);
        chk("lit_post_rst_ir", ir_data, 16'hA5A5);
        for (int n = 0; n < 200; n++) begin
            int w, fl;
            w = int'($urandom_range(0, MAXW));
            fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w + 1)) : -1;
            repeat ($urandom_range(0, 2)) idle_step();
            run_txn(16'($urandom), w, fl, 16'($urandom));
        end
        step();
        set_idle();
        step();
        set_idle();
        step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the LC-3b multicycle datapath, sitting directly upstream of the instruction register. On a fetch request from the control FSM it reads one 16-bit word from memory at the supplied PC, with a request/response handshake. It then delivers the word with a one-cycle load strobe that drives the instruction register's `load`/`in` pair. It also returns PC+2 for the PC mux and supports flushing an in-flight fetch.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum cycles in READ before abort. Used only with `IFETCH_TIMEOUT_EN`; must be ≥2.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low. One clock domain only.
- `fetch`  in  1  fetch request level, sampled in IDLE and LOAD.
- `pc`  in  16  instruction address, sampled on the accepting edge.
- `flush`  in  1  discard current fetch; no `ir_load` for it.
- `mem_resp`  in  1  memory completion, valid only while `mem_read`=1.
- `mem_rdata`  in  16  read data, valid with `mem_resp`.
- `mem_read`  out  1  registered read strobe.
- `mem_address`  out  16  registered; `{pc[15:1],1'b0}` of the accepted fetch.
- `ir_load`  out  1  one-cycle strobe to the IR `load` input.
- `ir_data`  out  16  registered instruction word to the IR `in` input.
- `pc_plus2`  out  16  registered `pc+2` of the accepted fetch, modulo 2^16.
- `busy`  out  1  high in READ and LOAD.
- `fault`  out  1  sticky timeout flag; tied 0 without `IFETCH_TIMEOUT_EN`.

## Operation
- States: IDLE, READ, LOAD.
- **IDLE**
  - If `fetch`=1 and `flush`=0: capture `pc`, set `mem_address`/`pc_plus2`, clear `fault` and `drop`, then go to READ.
  - Otherwise stay in IDLE.
- **READ**
  - `mem_read`=1 and `mem_address` stay stable until `mem_resp`.
  - On `mem_resp`=1 with `drop`=0 and `flush`=0: `ir_data`←`mem_rdata`, go to LOAD.
  - On `mem_resp`=1 with `drop`=1 or `flush`=1: discard the data, go to IDLE; `ir_data` is unchanged.
- **Flush during READ:** the memory handshake is never abandoned. Set `drop`; `mem_read` stays high until `mem_resp`.
- **LOAD**
  - `ir_load`=1 for exactly this cycle.
  - If `fetch`=1 and `flush`=0: accept a new PC and go straight to READ (back-to-back).
  - Otherwise go to IDLE.
  - `flush` in LOAD does not cancel the current strobe. It only blocks acceptance of a new fetch.
- `fetch` in READ is ignored; there is no queueing.
- An odd `pc` is silently aligned down to an even address.
- `pc_plus2` wraps: 0xFFFE gives 0x0000.

## Timing
- Reset value of every output: 0. Internal state: IDLE, `drop`=0, timer=0.
- Reset asserted mid-READ: `mem_read` drops asynchronously. The memory side must tolerate this.
- Latency from the accepting edge k:
  - `mem_read` is high from cycle k+1.
  - With `mem_resp` in the first READ cycle, `ir_load` is high in cycle k+2.
  - Each memory wait cycle adds one cycle.
- Throughput: one instruction per 2+W cycles, where W = memory wait cycles.
- `ir_data` and `pc_plus2` are stable from the LOAD cycle until the next accepted fetch completes or is accepted, respectively.

## Configuration
- `IFETCH_TIMEOUT_EN` defined:
  - A counter counts READ cycles.
  - If `TIMEOUT_CYCLES` READ cycles elapse with no `mem_resp`: drop `mem_read`, go to IDLE, set `fault`=1.
  - `fault` is held until the next accepted fetch; no `ir_load` is issued.
- `IFETCH_TIMEOUT_EN` undefined:
  - No counter is instantiated; READ waits indefinitely.
  - `fault` is constant 0.

## Structure
- `lc3b_types` package: `lc3b_word` (existing), plus a new enum `lc3b_ifetch_state` {IDLE, READ, LOAD}.
- `TIMEOUT_CYCLES` stays a module parameter.
- One sub-module is natural: `ifetch_watchdog`, the READ-cycle counter with clear/enable/expired. It is instantiated only under `IFETCH_TIMEOUT_EN`.
- Everything else lives in one module.

## Test plan
- Reset, then `fetch`=1 with `pc`=0x3001, zero-wait memory returning 0x1261:
  - `mem_address`=0x3000 in cycle 1;
  - `ir_load`=1 with `ir_data`=0x1261 and `pc_plus2`=0x3003 in cycle 2;
  - then IDLE.
- `pc`=0xFFFE with 3 wait cycles: `mem_read` is high for 4 cycles, `ir_load` is high in cycle 5, `pc_plus2`=0x0000.
- `flush` pulsed in the 2nd of 4 READ cycles: `mem_read` is held until `mem_resp`, no `ir_load`, `ir_data` keeps its prior value, and `busy` falls the next cycle.
- `fetch` held high continuously with zero-wait memory: `ir_load` pulses every 2nd cycle, each with the matching `pc_plus2`; `fetch` during READ is ignored.
- With `IFETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no `mem_resp`:
  - `mem_read` is high for 4 cycles, then `fault`=1 and no `ir_load`;
  - the next fetch clears `fault`.
- `rst_n` asserted mid-READ: all outputs are 0 immediately, without waiting for a clock edge; after release the block is idle and accepts a new fetch normally.
